seg_display_arbiter: RTL and testbench

Shares the 4-digit seven-segment display between two requesters, for example a CPU register view and a ROM address/debug view. Owner selection is round-robin, with a minimum hold time measured in prescaled ticks. The granted requester's 16-bit value is driven onto the four nibble inputs of the display driver. BLANK is raised while no requester owns the display.

---
 rtl/seg_display_arbiter_if.sv | 25 ++
 rtl/seg_display_arbiter.sv | 157 +++++++++++++++
 tb/tb_seg_display_arbiter.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/seg_display_arbiter_if.sv
// Requester/display bundle for the seven-segment display arbiter.
// master = requester side (drives REQ/DATA), slave = arbiter side (drives grants and digits).
interface seg_display_arbiter_if;
    logic        req_a;
    logic [15:0] data_a;
    logic        req_b;
    logic [15:0] data_b;
    logic        gnt_a;
    logic        gnt_b;
    logic [3:0]  d1;
    logic [3:0]  d2;
    logic [3:0]  d3;
    logic [3:0]  d4;
    logic        blank;

    modport master (
        output req_a, data_a, req_b, data_b,
        input  gnt_a, gnt_b, d1, d2, d3, d4, blank
    );

    modport slave (
        input  req_a, data_a, req_b, data_b,
        output gnt_a, gnt_b, d1, d2, d3, d4, blank
    );
endinterface

// File: rtl/seg_display_arbiter.sv
// Round-robin owner of the 4-digit seven-segment display with a minimum hold in prescaled ticks.
// Optional macro SEG_ARB_TIMEOUT_EN adds a forced release after MAX_TICKS plus a requester lockout.
module seg_display_arbiter #(
    parameter int TICK_DIV   = 50000,
    parameter int HOLD_TICKS = 4,
    parameter int MAX_TICKS  = 16
) (
    input  logic                  clk_i,
    input  logic                  in_clr_i,
    seg_display_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    localparam int PW = $clog2(TICK_DIV);
    // Counter is wide enough for either limit so both builds share one width.
    localparam int HW = $clog2(((MAX_TICKS > HOLD_TICKS) ? MAX_TICKS : HOLD_TICKS) + 1);
`ifdef SEG_ARB_TIMEOUT_EN
    localparam int HOLD_LIM = MAX_TICKS;
`else
    localparam int HOLD_LIM = HOLD_TICKS;
`endif

    state_t        state_q, state_d;
    logic          last_q, last_d;       // 0: A owned last, 1: B owned last
    logic [PW-1:0] presc_q, presc_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [15:0]   disp_q, disp_d;
    logic          tick;
    logic          held;
    logic          req_a_eff;
    logic          req_b_eff;

`ifdef SEG_ARB_TIMEOUT_EN
    logic lock_a_q, lock_a_d;
    logic lock_b_q, lock_b_d;
    logic timeout;

    assign req_a_eff = bus.req_a & ~lock_a_q;
    assign req_b_eff = bus.req_b & ~lock_b_q;
    assign timeout   = (hold_q == HW'(MAX_TICKS));
`else
    assign req_a_eff = bus.req_a;
    assign req_b_eff = bus.req_b;
`endif

    assign tick    = (presc_q == PW'(TICK_DIV - 1));
    assign presc_d = tick ? '0 : presc_q + PW'(1);
    assign held    = (hold_q >= HW'(HOLD_TICKS));

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        hold_d  = hold_q;
        disp_d  = disp_q;
`ifdef SEG_ARB_TIMEOUT_EN
        lock_a_d = lock_a_q & bus.req_a;
        lock_b_d = lock_b_q & bus.req_b;
`endif
        if (tick && (hold_q != HW'(HOLD_LIM))) begin
            hold_d = hold_q + HW'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (req_a_eff && (!req_b_eff || last_q)) begin
                    state_d = OWN_A;
                    last_d  = 1'b0;
                    hold_d  = '0;
                end else if (req_b_eff) begin
                    state_d = OWN_B;
                    last_d  = 1'b1;
                    hold_d  = '0;
                end
            end
            OWN_A: begin
                if (bus.req_a) begin
                    disp_d = bus.data_a;
                end
                if (held && req_b_eff) begin
                    state_d = OWN_B;
                    last_d  = 1'b1;
                    hold_d  = '0;
                end else if (held && !bus.req_a) begin
                    state_d = IDLE;
`ifdef SEG_ARB_TIMEOUT_EN
                end else if (timeout && !req_b_eff) begin
                    state_d  = IDLE;
                    lock_a_d = 1'b1;
`endif
                end
            end
            OWN_B: begin
                if (bus.req_b) begin
                    disp_d = bus.data_b;
                end
                if (held && req_a_eff) begin
                    state_d = OWN_A;
                    last_d  = 1'b0;
                    hold_d  = '0;
                end else if (held && !bus.req_b) begin
                    state_d = IDLE;
`ifdef SEG_ARB_TIMEOUT_EN
                end else if (timeout && !req_a_eff) begin
                    state_d  = IDLE;
                    lock_b_d = 1'b1;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge in_clr_i) begin
        if (in_clr_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            presc_q <= '0;
            hold_q  <= '0;
            disp_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            presc_q <= presc_d;
            hold_q  <= hold_d;
            disp_q  <= disp_d;
        end
    end

`ifdef SEG_ARB_TIMEOUT_EN
    always_ff @(posedge clk_i or posedge in_clr_i) begin
        if (in_clr_i) begin
            lock_a_q <= 1'b0;
            lock_b_q <= 1'b0;
        end else begin
            lock_a_q <= lock_a_d;
            lock_b_q <= lock_b_d;
        end
    end
`endif

    // Grants and blank come straight from the state flops, so they are registered.
    assign bus.gnt_a = (state_q == OWN_A);
    assign bus.gnt_b = (state_q == OWN_B);
    assign bus.blank = (state_q == IDLE);
    assign bus.d1    = disp_q[3:0];
    assign bus.d2    = disp_q[7:4];
    assign bus.d3    = disp_q[11:8];
    assign bus.d4    = disp_q[15:12];

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Bench for seg_display_arbiter: directed scenarios plus random traffic against a behavioural model.
// Define SEG_ARB_TIMEOUT_EN for both DUT and bench to exercise the timeout/lockout feature.
module tb_seg_display_arbiter;

    localparam int TD   = 4;
    localparam int HT   = 2;
    localparam int MT   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    seg_display_arbiter_if bus();

    seg_display_arbiter #(
        .TICK_DIV   (TD),
        .HOLD_TICKS (HT),
        .MAX_TICKS  (MT)
    ) dut (
        .clk_i    (clk),
        .in_clr_i (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: owner 0=none,1=A,2=B; ticks counts prescaler pulses since the grant.
    int          m_owner = 0;
    int          m_last  = 2;
    int          m_phase = 0;
    int          m_ticks = 0;
    logic [15:0] m_disp  = '0;
    bit          m_lock_a = 0;
    bit          m_lock_b = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner = 0; m_last = 2; m_phase = 0; m_ticks = 0;
            m_disp = '0; m_lock_a = 0; m_lock_b = 0;
        end else begin
            bit tk, ra, rb, held, to_a, to_b;
            tk   = (m_phase == TD - 1);
            m_phase = (m_phase + 1) % TD;
            ra   = bus.req_a && !m_lock_a;
            rb   = bus.req_b && !m_lock_b;
            held = (m_ticks >= HT);
            to_a = 0; to_b = 0;
`ifdef SEG_ARB_TIMEOUT_EN
            to_a = (m_owner == 1) && (m_ticks >= MT) && bus.req_a && !rb;
            to_b = (m_owner == 2) && (m_ticks >= MT) && bus.req_b && !ra;
`endif
            if (!bus.req_a) m_lock_a = 0;
            if (!bus.req_b) m_lock_b = 0;
            if (m_owner == 0) begin
                if (ra && (!rb || m_last == 2)) begin
                    m_owner = 1; m_last = 1; m_ticks = 0;
                end else if (rb) begin
                    m_owner = 2; m_last = 2; m_ticks = 0;
                end
            end else if (m_owner == 1) begin
                if (bus.req_a) m_disp = bus.data_a;
                if (held && rb)            begin m_owner = 2; m_last = 2; m_ticks = 0; end
                else if (held && !bus.req_a) m_owner = 0;
                else if (to_a)             begin m_owner = 0; m_lock_a = 1; end
                else if (tk)               m_ticks++;
            end else begin
                if (bus.req_b) m_disp = bus.data_b;
                if (held && ra)            begin m_owner = 1; m_last = 1; m_ticks = 0; end
                else if (held && !bus.req_b) m_owner = 0;
                else if (to_b)             begin m_owner = 0; m_lock_b = 1; end
                else if (tk)               m_ticks++;
            end
        end
    end

    always @(negedge clk) begin
        logic [18:0] act, exp;
        exp = {m_owner == 1, m_owner == 2, m_owner == 0, m_disp};
        act = {bus.gnt_a, bus.gnt_b, bus.blank, bus.d4, bus.d3, bus.d2, bus.d1};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL model_cmp t=%0t got=%h expected=%h", $time, act, exp);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] disp();
        return {bus.d4, bus.d3, bus.d2, bus.d1};
    endfunction

    task automatic wait_gnt(input bit sel_b, input logic val, input int budget, input string name);
        int n;
        n = 0;
        while (((sel_b ? bus.gnt_b : bus.gnt_a) !== val) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, sel_b ? bus.gnt_b : bus.gnt_a, val);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bus.req_a = 0; bus.req_b = 0; bus.data_a = '0; bus.data_b = '0;
        repeat (2) @(negedge clk);
        chk("reset_gnt", {bus.gnt_a, bus.gnt_b}, 2'b00);
        chk("reset_blank", bus.blank, 1'b1);
        chk("reset_disp", disp(), 16'h0000);

        // single owner
        rst = 0; bus.req_a = 1; bus.data_a = 16'h1234;
        @(negedge clk);
        chk("single_grant", {bus.gnt_a, bus.blank}, 2'b10);
        chk("single_first_edge_noload", disp(), 16'h0000);
        @(negedge clk);
        chk("single_data", disp(), 16'h1234);
        repeat (10) @(negedge clk);
        bus.req_a = 0;
        wait_gnt(0, 1'b0, 12, "single_release");
        chk("single_idle_blank", bus.blank, 1'b1);
        chk("single_idle_disp", disp(), 16'h1234);

        // asynchronous reset mid-count with REQ_A high
        bus.req_a = 1;
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_outs", {bus.gnt_a, bus.blank, disp()}, {2'b01, 16'h0000});
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_grant", bus.gnt_a, 1'b1);

        // contention from reset
        do_reset();
        bus.req_a = 1; bus.req_b = 1; bus.data_a = 16'h1111; bus.data_b = 16'hBEEF;
        @(negedge clk);
        chk("cont_a_first", {bus.gnt_a, bus.gnt_b}, 2'b10);
        wait_gnt(1, 1'b1, 20, "cont_handoff_b");
        chk("cont_no_overlap", bus.gnt_a, 1'b0);
        @(negedge clk);
        chk("cont_data_b", disp(), 16'hBEEF);
        wait_gnt(0, 1'b1, 20, "cont_back_to_a");
        chk("cont_b_dropped", bus.gnt_b, 1'b0);

        // early drop before held
        bus.req_b = 0;
        do_reset();
        bus.req_a = 1; bus.data_a = 16'h5678;
        @(negedge clk);
        chk("early_grant", bus.gnt_a, 1'b1);
        @(negedge clk);
        bus.req_a = 0; bus.data_a = 16'hFFFF;
        @(negedge clk);
        chk("early_still_owned", bus.gnt_a, 1'b1);
        chk("early_frozen", disp(), 16'h5678);
        wait_gnt(0, 1'b0, 12, "early_release");
        chk("early_final_disp", disp(), 16'h5678);

        // reset while B owns
        do_reset();
        bus.req_b = 1; bus.data_b = 16'hABCD;
        repeat (3) @(negedge clk);
        chk("b_owns", {bus.gnt_b, disp()}, {1'b1, 16'hABCD});
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("b_rst_outs", {bus.gnt_a, bus.gnt_b, bus.blank, disp()}, {3'b001, 16'h0000});
        @(negedge clk);
        rst = 1'b0; bus.req_a = 1; bus.req_b = 1;
        @(negedge clk);
        chk("b_rst_a_wins", {bus.gnt_a, bus.gnt_b}, 2'b10);

`ifdef SEG_ARB_TIMEOUT_EN
        begin
            bit seen;
            bus.req_b = 0;
            do_reset();
            bus.req_a = 1;
            wait_gnt(0, 1'b1, 4, "to_grant");
            wait_gnt(0, 1'b0, 40, "to_forced_release");
            seen = 0;
            repeat (20) begin
                @(negedge clk);
                if (bus.gnt_a) seen = 1;
            end
            chk("to_lockout", seen, 1'b0);
            bus.req_a = 0;
            @(negedge clk);
            bus.req_a = 1;
            wait_gnt(0, 1'b1, 4, "to_regrant");
        end
`endif

        // random traffic checked by the model process
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) bus.req_a = ~bus.req_a;
            if ($urandom_range(0, 7) == 0) bus.req_b = ~bus.req_b;
            bus.data_a = 16'($urandom);
            bus.data_b = 16'($urandom);
            if ($urandom_range(0, 499) == 0) do_reset();
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
